// File: rtl/spi_master_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_seq
// Description : Command-FIFO driven SPI master; 18-bit frames (7b header +
//               11b payload), LSB first, read data returned on a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_seq #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_OFS     = 2,
    parameter int CS_GAP     = 2,
    parameter int BURST      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [4:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [4:0] rsp_addr,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_cs,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = 8;

    localparam logic [4:0] c_LAST_BIT = 5'd17;
    localparam logic [4:0] c_RD_FIRST = 5'(7 + RD_OFS);
    localparam logic [4:0] c_RD_LAST  = 5'(14 + RD_OFS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } t_state;

    t_state             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [4:0]         r_bitcnt;
    logic [GAP_W-1:0]   r_gapcnt;
    logic [17:0]        r_frame;
    logic               r_is_rd;
    logic [4:0]         r_cur_addr;
    logic [7:0]         r_rxsh;
    logic               r_sclk;
    logic               r_cs;
    logic               r_mosi;
    logic               r_rsp_valid;
    logic [4:0]         r_rsp_addr;
    logic [7:0]         r_rsp_rdata;

    // Command FIFO entry: {write, addr[4:0], wdata[7:0]}
    logic [13:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_tick;
    logic               w_frame_end;
    logic [13:0]        w_head;
    logic [17:0]        w_head_frame;

    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = cmd_valid && !w_full;
    assign w_head       = r_mem[r_rptr];
    assign w_head_frame = {3'b000, (w_head[13] ? w_head[7:0] : 8'h00),
                           1'b0, w_head[12:8], w_head[13]};

    assign w_tick      = (r_state != S_IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_frame_end = (r_state == S_SHIFT) && w_tick && r_sclk
                         && (r_bitcnt == c_LAST_BIT);
    assign w_pop       = !w_empty && ((r_state == S_IDLE)
                         || ((BURST != 0) && w_frame_end));

    assign cmd_ready = !w_full;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign spi_sclk  = r_sclk;
    assign spi_cs    = r_cs;
    assign spi_mosi  = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_rdata = r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_gapcnt    <= '0;
            r_frame     <= '0;
            r_is_rd     <= 1'b0;
            r_cur_addr  <= '0;
            r_rxsh      <= '0;
            r_sclk      <= 1'b0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_frame    <= w_head_frame;
                        r_is_rd    <= !w_head[13];
                        r_cur_addr <= w_head[12:8];
                        r_mosi     <= w_head_frame[0];
                        r_bitcnt   <= '0;
                        r_sclk     <= 1'b0;
                        r_cs       <= 1'b0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tick) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick && !r_sclk) begin
                        r_sclk <= 1'b1;
                        if (r_is_rd && r_bitcnt >= c_RD_FIRST && r_bitcnt <= c_RD_LAST) begin
                            r_rxsh <= {spi_miso, r_rxsh[7:1]};
                        end
                    end else if (w_tick) begin
                        r_sclk <= 1'b0;
                        if (r_bitcnt == c_LAST_BIT) begin
                            if (r_is_rd) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_addr  <= r_cur_addr;
                                r_rsp_rdata <= r_rxsh;
                            end
                            // Burst: the next frame's first bit occupies the
                            // half-period that would otherwise be HOLD.
                            if (w_pop) begin
                                r_frame    <= w_head_frame;
                                r_is_rd    <= !w_head[13];
                                r_cur_addr <= w_head[12:8];
                                r_mosi     <= w_head_frame[0];
                                r_bitcnt   <= '0;
                            end else begin
                                r_state <= S_HOLD;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 5'd1;
                            r_mosi   <= r_frame[r_bitcnt + 5'd1];
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_cs     <= 1'b1;
                        r_mosi   <= 1'b0;
                        r_gapcnt <= '0;
                        r_state  <= (CS_GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_gapcnt == GAP_W'(CS_GAP - 1)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gapcnt <= r_gapcnt + GAP_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
